// File: rtl/day1_full_adder.sv
// Registered WIDTH-bit ripple-carry adder producing Sum, Cout and signed overflow with a travelling valid bit.
// Optional input register stage enabled by defining DAY1_FULL_ADDER_INREG_EN (latency 2 instead of 1).
module day1_full_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    logic [WIDTH-1:0] op_a_s;
    logic [WIDTH-1:0] op_b_s;
    logic             op_cin_s;
    logic             op_valid_s;
    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] sum_s;
    logic             valid_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;

`ifdef DAY1_FULL_ADDER_INREG_EN
    logic [WIDTH-1:0] a_in_r;
    logic [WIDTH-1:0] b_in_r;
    logic             cin_in_r;
    logic             valid_in_r;

    // Input stage: operands load only when valid so idle X/Z never enters the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_in_r     <= '0;
            b_in_r     <= '0;
            cin_in_r   <= 1'b0;
            valid_in_r <= 1'b0;
        end else begin
            valid_in_r <= in_valid;
            if (in_valid) begin
                a_in_r   <= A;
                b_in_r   <= B;
                cin_in_r <= Cin;
            end
        end
    end

    assign op_a_s     = a_in_r;
    assign op_b_s     = b_in_r;
    assign op_cin_s   = cin_in_r;
    assign op_valid_s = valid_in_r;
`else
    assign op_a_s     = A;
    assign op_b_s     = B;
    assign op_cin_s   = Cin;
    assign op_valid_s = in_valid;
`endif

    // Ripple chain of 1-bit full-adder cells, LSB first.
    always_comb begin
        carry_s    = '0;
        sum_s      = '0;
        carry_s[0] = op_cin_s;
        for (int i = 0; i < WIDTH; i++) begin
            sum_s[i]     = op_a_s[i] ^ op_b_s[i] ^ carry_s[i];
            carry_s[i+1] = (op_a_s[i] & op_b_s[i]) | (carry_s[i] & (op_a_s[i] ^ op_b_s[i]));
        end
    end

    // Output stage: results load on valid and hold otherwise; only the valid flag drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            valid_r <= op_valid_s;
            if (op_valid_s) begin
                sum_r  <= sum_s;
                cout_r <= carry_s[WIDTH];
                ovf_r  <= carry_s[WIDTH] ^ carry_s[WIDTH-1];
            end
        end
    end

    assign out_valid = valid_r;
    assign Sum       = sum_r;
    assign Cout      = cout_r;
    assign Ovf       = ovf_r;

endmodule

// File: tb/tb_day1_full_adder.sv
// Self-checking bench for day1_full_adder at WIDTH 4, 1 and 32 against an arithmetic reference model.
// Latency expectation follows DAY1_FULL_ADDER_INREG_EN.
module tb_day1_full_adder;

`ifdef DAY1_FULL_ADDER_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  a4, b4, sum4;
    logic        c4, cout4, ovf4, ov4;
    logic        a1, b1, sum1;
    logic        c1, cout1, ovf1, ov1;
    logic [31:0] a32, b32, sum32;
    logic        c32, cout32, ovf32, ov32;

    int checks;
    int errors;

    typedef struct packed {
        logic            v;
        logic [2:0]      c;
        logic [2:0]      o;
        logic [2:0][31:0] s;
    } res_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    res_t pipe_q[$];
    res_t exp_r;
    vec_t tbl[6];

    day1_full_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a4), .B(b4), .Cin(c4),
        .out_valid(ov4), .Sum(sum4), .Cout(cout4), .Ovf(ovf4));
    day1_full_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a1), .B(b1), .Cin(c1),
        .out_valid(ov1), .Sum(sum1), .Cout(cout1), .Ovf(ovf1));
    day1_full_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a32), .B(b32), .Cin(c32),
        .out_valid(ov32), .Sum(sum32), .Cout(cout32), .Ovf(ovf32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {ovf, cout, sum} from plain unsigned and signed arithmetic.
    function automatic logic [33:0] ref_add(input longint unsigned a, input longint unsigned b,
                                            input logic c, input int w);
        longint unsigned one, mask, full;
        longint sa, sb, sv, hi, lo;
        logic cout, ovf;
        one  = 64'd1;
        mask = (one << w) - one;
        full = (a & mask) + (b & mask) + longint'(c);
        cout = ((full >> w) & one) != 0;
        sa = longint'(a & mask);
        sb = longint'(b & mask);
        if (((a >> (w - 1)) & one) != 0) sa = sa - longint'(one << w);
        if (((b >> (w - 1)) & one) != 0) sb = sb - longint'(one << w);
        sv  = sa + sb + longint'(c);
        hi  = longint'(one << (w - 1)) - 1;
        lo  = -longint'(one << (w - 1));
        ovf = (sv > hi) || (sv < lo);
        return {ovf, cout, 32'(full & mask)};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_w4"},  {29'b0, ov4,  cout4,  ovf4,  32'(sum4)},
                             {29'b0, exp_r.v, exp_r.c[0], exp_r.o[0], exp_r.s[0]});
        check({tag, "_w1"},  {29'b0, ov1,  cout1,  ovf1,  32'(sum1)},
                             {29'b0, exp_r.v, exp_r.c[1], exp_r.o[1], exp_r.s[1]});
        check({tag, "_w32"}, {29'b0, ov32, cout32, ovf32, sum32},
                             {29'b0, exp_r.v, exp_r.c[2], exp_r.o[2], exp_r.s[2]});
    endtask

    task automatic reset_model();
        pipe_q.delete();
        exp_r = '0;
        for (int i = 0; i < LAT - 1; i++) pipe_q.push_back(res_t'(0));
    endtask

    // One clock: drive at negedge, advance the model at posedge, compare at the next negedge.
    task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b, input logic c);
        res_t r;
        logic [33:0] t;
        in_valid = v;
        a4 = a; b4 = b; c4 = c;
        a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
        a32 = $urandom; b32 = $urandom; c32 = 1'($urandom);
        r = '0;
        r.v = v;
        t = ref_add(64'(a4), 64'(b4), c4, 4);
        r.s[0] = t[31:0]; r.c[0] = t[32]; r.o[0] = t[33];
        t = ref_add(64'(a1), 64'(b1), c1, 1);
        r.s[1] = t[31:0]; r.c[1] = t[32]; r.o[1] = t[33];
        t = ref_add(64'(a32), 64'(b32), c32, 32);
        r.s[2] = t[31:0]; r.c[2] = t[32]; r.o[2] = t[33];
        pipe_q.push_back(r);
        @(posedge clk);
        r = pipe_q.pop_front();
        exp_r.v = r.v;
        if (r.v) begin
            exp_r.s = r.s;
            exp_r.c = r.c;
            exp_r.o = r.o;
        end
        @(negedge clk);
        compare_all("step");
    endtask

    task automatic reset_mid();
        rst_n = 1'b0;
        #1;
        check("rst_async_w4",  {60'b0, ov4, cout4, ovf4, |sum4}, 64'd0);
        check("rst_async_w1",  {60'b0, ov1, cout1, ovf1, sum1}, 64'd0);
        check("rst_async_w32", {60'b0, ov32, cout32, ovf32, |sum32}, 64'd0);
        reset_model();
        @(posedge clk);
        @(negedge clk);
        compare_all("rst_held");
        rst_n = 1'b1;
    endtask

    initial begin
        int j;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        a4 = '0; b4 = '0; c4 = 1'b0;
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        a32 = '0; b32 = '0; c32 = 1'b0;

        tbl[0] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1};
        tbl[1] = '{4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0, 1'b0};
        tbl[2] = '{4'b1000, 4'b1101, 1'b1, 4'b0110, 1'b1, 1'b1};
        tbl[3] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1, 1'b0};
        tbl[4] = '{4'b1010, 4'b1100, 1'b0, 4'b0110, 1'b1, 1'b1};
        tbl[5] = '{4'b1101, 4'b0111, 1'b0, 4'b0100, 1'b1, 1'b0};

        #2;
        reset_model();
        compare_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed stream, each result checked against the table LAT cycles later.
        for (int i = 0; i < 6 + LAT - 1; i++) begin
            if (i < 6) step(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin);
            else       step(1'b0, 4'b1111, 4'b1111, 1'b0);
            j = i - (LAT - 1);
            if (j >= 0 && j < 6)
                check("table", {57'b0, ov4, cout4, ovf4, sum4},
                      {57'b0, 1'b1, tbl[j].cout, tbl[j].ovf, tbl[j].sum});
        end

        // Idle with 1111 operands: valid drops, result holds.
        step(1'b0, 4'b1111, 4'b1111, 1'b0);
        check("hold", {58'b0, ov4, cout4, sum4}, {58'b0, 1'b0, 1'b1, 4'b0100});

        // Exhaustive WIDTH=4 stream with occasional X operands while idle.
        for (int k = 0; k < 512; k++) begin
            step(1'b1, k[3:0], k[7:4], k[8]);
            if ((k % 64) == 63) step(1'b0, 4'bxxxx, 4'bxxxx, 1'bx);
        end

        // Random valid/idle mix.
        for (int k = 0; k < 300; k++)
            step(($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 1'($urandom));

        // Reset with operations in flight, then restart the stream.
        step(1'b1, 4'b0011, 4'b0100, 1'b1);
        step(1'b1, 4'b1001, 4'b1001, 1'b0);
        reset_mid();
        for (int k = 0; k < 8; k++)
            step(1'b1, 4'($urandom), 4'($urandom), 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/day1_full_adder.md
Name: day1_full_adder

Overview:
- Registered WIDTH-bit ripple-carry adder: computes A + B + Cin and presents Sum, Cout and a signed-overflow flag one clock after a valid input.
- Datapath is built from a chain of 1-bit full-adder cells.
- Used as a leaf arithmetic block; a valid bit travels alongside the data so upstream and downstream logic can stream operands every cycle.

Parameters:
- WIDTH, 4, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  A/B/Cin are valid this cycle.
- A  input  WIDTH  operand A (unsigned, or two's complement for Ovf).
- B  input  WIDTH  operand B.
- Cin  input  1  carry in.
- out_valid  output  1  Sum/Cout/Ovf are valid.
- Sum  output  WIDTH  low WIDTH bits of A+B+Cin.
- Cout  output  1  carry out of MSB (bit WIDTH of the full sum).
- Ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: rst_n low asynchronously clears out_valid, Sum, Cout and Ovf to 0. Outputs stay 0 while rst_n is low; release is synchronous to the next clk edge.
- Datapath:
  - Combinational chain of WIDTH full-adder cells: s[i] = a^b^c[i]; c[i+1] = a&b | c[i]&(a^b); c[0] = Cin.
  - Cout = c[WIDTH]; Ovf = c[WIDTH] ^ c[WIDTH-1].
- Latency: 1 cycle.
  - On a rising clk edge with in_valid=1: Sum/Cout/Ovf register the result and out_valid is set to 1.
  - With in_valid=0: out_valid is set to 0 and Sum/Cout/Ovf hold their previous values. They do not clear.
- Throughput: one operation per cycle. Back-to-back valid inputs produce back-to-back valid outputs in order. There is no backpressure.
- Wrap-around: the sum is modulo 2^WIDTH. The carry is reported only on Cout; e.g. all-ones + 0 + Cin=1 gives Sum=0, Cout=1.
- Inputs containing X/Z while in_valid=0 must not affect the outputs.
- Reset mid-stream: in-flight results are discarded. The first out_valid after reset corresponds to the first in_valid sampled after release.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: DAY1_FULL_ADDER_INREG_EN.
- When defined:
  - An extra input register stage (A, B, Cin, in_valid), reset to 0 by rst_n, is inserted before the adder chain.
  - Latency becomes 2 cycles; throughput stays 1 per cycle.
  - The hold-on-invalid rule applies at the output stage.
- When undefined: latency is 1 cycle as described above.
- Function and flag definitions are identical in both builds.

Test Plan:
1. Reset: assert rst_n=0 mid-operation -> out_valid=0, Sum=0, Cout=0, Ovf=0 immediately (no clock needed).
2. Stream five back-to-back valid operations (WIDTH=4). Each result appears one cycle after its input (two with the macro):
   - A=1010, B=0101, Cin=0 -> Sum=1111, Cout=0, Ovf=0
   - A=1000, B=1101, Cin=1 -> Sum=0110, Cout=1, Ovf=1
   - A=0000, B=1111, Cin=1 -> Sum=0000, Cout=1, Ovf=0
   - A=1010, B=1100, Cin=0 -> Sum=0110, Cout=1, Ovf=1
   - A=1101, B=0111, Cin=0 -> Sum=0100, Cout=1, Ovf=0
3. Hold: after a valid op giving Sum=0100, drive in_valid=0 with A=1111, B=1111 -> out_valid=0 next cycle, Sum stays 0100, Cout stays 1.
4. Positive overflow: A=0111, B=0001, Cin=0 -> Sum=1000, Cout=0, Ovf=1.
5. Exhaustive: all 512 combinations of A, B, Cin for WIDTH=4 -> {Cout,Sum} == A+B+Cin and Ovf matches the signed-overflow reference. Repeat a random sample at WIDTH=1 and WIDTH=32.
6. Build with DAY1_FULL_ADDER_INREG_EN defined -> scenario 2 results appear exactly 2 cycles after each input, and reset clears both stages.
